// File: rtl/lamp_decoder_pkg.sv
// Shared definitions for the time-multiplexed lamp link (encoder and decoder).
// Keeps frame width and FSM encoding in agreement on both ends of the link.
package lamp_link_pkg;

   localparam int NUM_LAMPS_DEFAULT = 16;

   typedef enum logic [0:0] {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } lamp_state_t;

   typedef logic [NUM_LAMPS_DEFAULT-1:0] lamp_vec_t;

endpackage

// File: rtl/lamp_decoder_if.sv
// Lamp link bundle: slot stream from the encoder, committed frame and status back.
interface lamp_decoder_if
   import lamp_link_pkg::*;
#(
   parameter int NUM_LAMPS = NUM_LAMPS_DEFAULT
);

   localparam int ADDR_W = $clog2(NUM_LAMPS);

   logic [ADDR_W-1:0]    addr_in;
   logic                 enable_in;
   logic [NUM_LAMPS-1:0] lamp_out;
   logic                 frame_valid;
   logic                 locked;
   logic                 seq_error;

   modport master (
      output addr_in,
      output enable_in,
      input  lamp_out,
      input  frame_valid,
      input  locked,
      input  seq_error
   );

   modport slave (
      input  addr_in,
      input  enable_in,
      output lamp_out,
      output frame_valid,
      output locked,
      output seq_error
   );

endinterface

// File: rtl/lamp_decoder.sv
// Lamp link receiver: follows the slot sequence, rebuilds a shadow frame and
// commits it to lamp_out only when a complete, in-order frame has arrived.
module lamp_decoder
   import lamp_link_pkg::*;
#(
   parameter int NUM_LAMPS   = NUM_LAMPS_DEFAULT,
   parameter int LOCK_FRAMES = 2
) (
   input  logic           clk,
   input  logic           reset,
   lamp_decoder_if.slave  lnk
);

   localparam int ADDR_W = $clog2(NUM_LAMPS);
   localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LAMPS - 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);

   lamp_state_t          state_r, state_s;
   logic [ADDR_W-1:0]    expected_r, expected_s;
   logic [NUM_LAMPS-1:0] shadow_r, shadow_s;
   logic [NUM_LAMPS-1:0] lamp_r, lamp_s;
   logic [GOOD_W-1:0]    good_cnt_r, good_cnt_s;
   logic                 frame_valid_r, frame_valid_s;
   logic                 locked_r, locked_s;
   logic                 seq_error_r, seq_error_s;

   // Next-state and datapath decode for the slot tracker
   always_comb begin
      state_s       = state_r;
      expected_s    = expected_r;
      shadow_s      = shadow_r;
      lamp_s        = lamp_r;
      good_cnt_s    = good_cnt_r;
      frame_valid_s = 1'b0;
      seq_error_s   = 1'b0;

      case (state_r)
         HUNT: begin
            if (lnk.addr_in == {ADDR_W{1'b0}}) begin
               shadow_s[0] = lnk.enable_in;
               expected_s  = ADDR_W'(1);
               state_s     = COLLECT;
            end else begin
               state_s     = HUNT;
            end
         end
         COLLECT: begin
            if (lnk.addr_in == expected_r) begin
               shadow_s[expected_r] = lnk.enable_in;
               if (expected_r == LAST_ADDR) begin
                  // Final slot goes straight to the output; shadow_r does not hold it yet
                  lamp_s        = {lnk.enable_in, shadow_r[NUM_LAMPS-2:0]};
                  frame_valid_s = 1'b1;
                  expected_s    = {ADDR_W{1'b0}};
                  if (good_cnt_r == GOOD_MAX) begin
                     good_cnt_s = good_cnt_r;
                  end else begin
                     good_cnt_s = good_cnt_r + GOOD_W'(1);
                  end
               end else begin
                  expected_s    = expected_r + ADDR_W'(1);
               end
            end else begin
               // Offending sample is dropped even if it is slot 0; resync waits for the next one
               seq_error_s = 1'b1;
               good_cnt_s  = {GOOD_W{1'b0}};
               expected_s  = {ADDR_W{1'b0}};
               state_s     = HUNT;
            end
         end
         default: begin
            state_s    = HUNT;
            expected_s = {ADDR_W{1'b0}};
         end
      endcase

      locked_s = (good_cnt_s == GOOD_MAX);
   end

   // State, shadow and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= HUNT;
         expected_r    <= {ADDR_W{1'b0}};
         shadow_r      <= {NUM_LAMPS{1'b0}};
         lamp_r        <= {NUM_LAMPS{1'b0}};
         good_cnt_r    <= {GOOD_W{1'b0}};
         frame_valid_r <= 1'b0;
         locked_r      <= 1'b0;
         seq_error_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         expected_r    <= expected_s;
         shadow_r      <= shadow_s;
         lamp_r        <= lamp_s;
         good_cnt_r    <= good_cnt_s;
         frame_valid_r <= frame_valid_s;
         locked_r      <= locked_s;
         seq_error_r   <= seq_error_s;
      end
   end

   assign lnk.lamp_out    = lamp_r;
   assign lnk.frame_valid = frame_valid_r;
   assign lnk.locked      = locked_r;
   assign lnk.seq_error   = seq_error_r;

endmodule

// File: tb/tb_lamp_decoder.sv
// Directed self-checking bench for lamp_decoder with hand-computed frame values.
module tb_lamp_decoder;
   import lamp_link_pkg::*;

   logic clk;
   logic reset;

   int n_checks;
   int n_fail;
   int fv_cnt;
   int se_cnt;
   int glitch_cnt;
   int both_cnt;
   lamp_vec_t prev_lamp;

   lamp_decoder_if #(.NUM_LAMPS(16)) lnk ();

   lamp_decoder #(
      .NUM_LAMPS   (16),
      .LOCK_FRAMES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .lnk   (lnk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      lnk.addr_in = 4'd0;
      lnk.enable_in = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      prev_lamp = lnk.lamp_out;
   endtask

   // Drives slots first..last, one per clock, sampling outputs 1 time unit after each edge
   task automatic send_slots(input lamp_vec_t pat, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         lnk.addr_in = k[3:0];
         lnk.enable_in = pat[k[3:0]];
         @(posedge clk);
         #1;
         if (lnk.frame_valid) fv_cnt++;
         if (lnk.seq_error) se_cnt++;
         if (lnk.frame_valid && lnk.seq_error) both_cnt++;
         if ((lnk.lamp_out !== prev_lamp) && (k != 15)) glitch_cnt++;
         prev_lamp = lnk.lamp_out;
      end
   endtask

   task automatic clr_counts();
      fv_cnt = 0;
      se_cnt = 0;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      glitch_cnt = 0;
      both_cnt = 0;
      clr_counts();

      // 1: reset, then two frames of 0FA5
      do_reset();
      check("rst_lamp", 32'(lnk.lamp_out), 32'h0);
      check("rst_fv", 32'(lnk.frame_valid), 32'h0);
      check("rst_locked", 32'(lnk.locked), 32'h0);
      check("rst_se", 32'(lnk.seq_error), 32'h0);
      send_slots(16'h0FA5, 0, 14);
      check("t1_partial_fv", 32'(fv_cnt), 32'd0);
      check("t1_partial_lamp", 32'(lnk.lamp_out), 32'h0);
      send_slots(16'h0FA5, 15, 15);
      check("t1_f1_lamp", 32'(lnk.lamp_out), 32'h0FA5);
      check("t1_f1_fv", 32'(lnk.frame_valid), 32'h1);
      check("t1_f1_locked", 32'(lnk.locked), 32'h0);
      send_slots(16'h0FA5, 0, 0);
      check("t1_fv_pulse_end", 32'(lnk.frame_valid), 32'h0);
      send_slots(16'h0FA5, 1, 15);
      check("t1_f2_fv", 32'(lnk.frame_valid), 32'h1);
      check("t1_f2_locked", 32'(lnk.locked), 32'h1);
      clr_counts();
      send_slots(16'h0FA5, 0, 15);
      check("t1_f3_fv_count", 32'(fv_cnt), 32'd1);
      check("t1_f3_fv", 32'(lnk.frame_valid), 32'h1);

      // 2: new pattern, output must hold until the slot-15 edge then jump at once
      send_slots(16'hFFFF, 0, 14);
      check("t2_hold", 32'(lnk.lamp_out), 32'h0FA5);
      send_slots(16'hFFFF, 15, 15);
      check("t2_new", 32'(lnk.lamp_out), 32'hFFFF);

      // 3: skip slot 7 while locked
      clr_counts();
      send_slots(16'h1234, 0, 6);
      send_slots(16'h1234, 8, 8);
      check("t3_se", 32'(lnk.seq_error), 32'h1);
      check("t3_unlocked", 32'(lnk.locked), 32'h0);
      check("t3_lamp_kept", 32'(lnk.lamp_out), 32'hFFFF);
      send_slots(16'h1234, 9, 9);
      check("t3_se_pulse_end", 32'(lnk.seq_error), 32'h0);
      send_slots(16'h1234, 10, 15);
      check("t3_hunt_no_commit", 32'(fv_cnt), 32'd0);
      check("t3_hunt_one_err", 32'(se_cnt), 32'd1);
      check("t3_hunt_lamp", 32'(lnk.lamp_out), 32'hFFFF);
      send_slots(16'h1234, 0, 15);
      check("t3_resync_lamp", 32'(lnk.lamp_out), 32'h1234);
      check("t3_resync_locked", 32'(lnk.locked), 32'h0);
      send_slots(16'h1234, 0, 15);
      check("t3_relocked", 32'(lnk.locked), 32'h1);

      // 4: start mid-frame after reset
      do_reset();
      clr_counts();
      send_slots(16'h5A5A, 9, 15);
      check("t4_no_se", 32'(se_cnt), 32'd0);
      check("t4_no_commit", 32'(fv_cnt), 32'd0);
      check("t4_lamp_zero", 32'(lnk.lamp_out), 32'h0);
      send_slots(16'h5A5A, 0, 15);
      check("t4_first_commit", 32'(lnk.lamp_out), 32'h5A5A);
      check("t4_fv", 32'(lnk.frame_valid), 32'h1);

      // 5: reset at slot 10 while locked on 0FA5
      send_slots(16'h0FA5, 0, 15);
      send_slots(16'h0FA5, 0, 15);
      check("t5_pre_lamp", 32'(lnk.lamp_out), 32'h0FA5);
      check("t5_pre_locked", 32'(lnk.locked), 32'h1);
      send_slots(16'h3C3C, 0, 9);
      reset = 1'b1;
      lnk.addr_in = 4'd10;
      lnk.enable_in = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_lamp", 32'(lnk.lamp_out), 32'h0);
      check("t5_rst_locked", 32'(lnk.locked), 32'h0);
      check("t5_rst_fv", 32'(lnk.frame_valid), 32'h0);
      reset = 1'b0;
      prev_lamp = lnk.lamp_out;
      send_slots(16'h3C3C, 0, 15);
      check("t5_resume_lamp", 32'(lnk.lamp_out), 32'h3C3C);
      check("t5_resume_fv", 32'(lnk.frame_valid), 32'h1);

      // 6: slot 0 repeated
      clr_counts();
      send_slots(16'h00FF, 0, 0);
      check("t6_first0_ok", 32'(lnk.seq_error), 32'h0);
      send_slots(16'h00FF, 0, 0);
      check("t6_second0_se", 32'(lnk.seq_error), 32'h1);
      send_slots(16'h00FF, 1, 15);
      check("t6_no_commit", 32'(fv_cnt), 32'd0);
      check("t6_one_err", 32'(se_cnt), 32'd1);
      check("t6_lamp_kept", 32'(lnk.lamp_out), 32'h3C3C);
      send_slots(16'h00FF, 0, 15);
      check("t6_commit", 32'(lnk.lamp_out), 32'h00FF);
      check("t6_fv", 32'(lnk.frame_valid), 32'h1);

      check("no_intermediate_lamp", 32'(glitch_cnt), 32'd0);
      check("fv_se_exclusive", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
